// File: rtl/c1_response_checker.sv
// c1_response_checker: checks observed C1 responses, counts vectors/errors, captures first failure, compacts into a MISR
module c1_response_checker #(
    parameter int              SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             end_req,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       vec,
    input  logic             f_obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       first_fail_vec,
    output logic             first_fail_valid,
    output logic [SIG_W-1:0] signature
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;
    state_t state, state_nxt;
    logic m0, m1, f_exp, mis, clr, xfer;
    logic [SIG_W-1:0] sig_in, sig_nxt;

    // reference C1 model: vec is {SB,SA,S1,S0,A0,B0,A1,B1}
    always_comb begin
        m0 = vec[6] ? vec[2] : vec[3];
        m1 = vec[7] ? vec[0] : vec[1];
        f_exp = (vec[5] | vec[4]) ? m1 : m0;
        mis = f_obs != f_exp;
    end

    // start is ignored only while draining through FINISH; a start cycle never transfers
    assign clr      = start && state != FINISH;
    assign xfer     = in_valid && in_ready && !start;
    assign in_ready = state == RUN;
    assign busy     = state == RUN || state == FINISH;
    assign done     = state == DONE;
    assign pass     = done && err_cnt == '0 && vec_cnt != '0;

    // MISR step with the response {f_obs,vec} folded into the low bits
    always_comb begin
        sig_in = '0;
        sig_in[8:0] = {f_obs, vec};
        sig_nxt = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ sig_in;
    end

    // session sequencing
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = start ? RUN : end_req ? FINISH : RUN;
            FINISH:  state_nxt = DONE;
            default: state_nxt = start ? RUN : DONE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // session results: clear on start, update on each transfer, counters saturate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || clr) begin
            vec_cnt          <= '0;
            err_cnt          <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            signature        <= '0;
        end else if (xfer) begin
            vec_cnt   <= vec_cnt + CNT_W'(vec_cnt != '1);
            err_cnt   <= err_cnt + CNT_W'(mis && err_cnt != '1);
            signature <= sig_nxt;
            if (mis && !first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
            end
        end
    end
endmodule

// File: doc/c1_response_checker.md
# c1_response_checker

Self-test response checker for the C1 logic cell. It accepts a stream of applied C1 input vectors, each paired with the observed F output, and computes the expected F internally. Per session it counts vectors and mismatches, latches the first failing vector and compacts all responses into a MISR signature. It sits on the observe side of the C1/gate characterization path, opposite the stimulus source that drives the cell.

## Interface
- SIG_W, 16: MISR signature width; must be ≥ 9.
- POLY, 16'h1021: MISR feedback polynomial, SIG_W bits.
- CNT_W, 16: width of the vector and error counters.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- start  in  1  one-cycle pulse; clears the session and enters RUN.
- end_req  in  1  level; requests session end while in RUN.
- in_valid  in  1  vec/f_obs carry a response.
- in_ready  out  1  checker accepts a response; high only in RUN.
- vec  in  8  applied C1 inputs, bit order {SB,SA,S1,S0,A0,B0,A1,B1}.
- f_obs  in  1  observed C1 output for vec.
- busy  out  1  high in RUN and FINISH.
- done  out  1  high in DONE.
- pass  out  1  done && err_cnt==0 && vec_cnt!=0.
- vec_cnt  out  CNT_W  accepted responses, saturating.
- err_cnt  out  CNT_W  mismatching responses, saturating.
- first_fail_vec  out  8  vec of the first mismatch.
- first_fail_valid  out  1  first_fail_vec holds a capture.
- signature  out  SIG_W  MISR state.

## Operation
- Expected F is combinational:
  - M0 = SA ? B0 : A0
  - M1 = SB ? B1 : A1
  - F_exp = (S0|S1) ? M1 : M0
- A transfer occurs when in_valid && in_ready. On the transfer edge:
  - vec_cnt increments.
  - If f_obs != F_exp, err_cnt increments.
  - If the response mismatches and first_fail_valid==0, first_fail_vec ← vec and first_fail_valid ← 1.
  - signature ← {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended {f_obs,vec}.
- Counters saturate at all-ones. They never wrap.
- States and transitions:
  - IDLE → RUN on start.
  - RUN → FINISH on end_req. A transfer in the same cycle is still counted.
  - FINISH → DONE unconditionally, after one cycle.
  - DONE → RUN on start.
  - start in RUN restarts the session: clear and stay in RUN. start in FINISH is ignored.
- Clear, on start or rst: vec_cnt, err_cnt, signature, first_fail_vec and first_fail_valid all go to 0.
- When start and in_valid coincide, the start cycle performs no transfer. in_ready rises the next cycle.
- Outputs hold their values in DONE until start or rst.

## Timing
- Reset values:
  - state IDLE
  - in_ready=0, busy=0, done=0, pass=0
  - all counters, signature and first_fail_* are 0
- rst asserted mid-session clears everything immediately, independent of clk.
- in_ready, busy, done and pass are registered-state decodes. There is no combinational path from in_valid.
- Counter, signature and capture updates are visible 1 cycle after the transfer edge.
- done rises 2 cycles after the edge that samples end_req (RUN → FINISH → DONE).
- Throughput: 1 response per cycle.

## Test plan
- Reset, start, then 3 transfers:
  - vec=8'h08, f=1: F_exp=1.
  - vec=8'h21, f=0: F_exp=0.
  - vec=8'h91, f=1: F_exp=1.
  - Then end_req.
  - Required: after 2 cycles done=1, pass=1, vec_cnt=3, err_cnt=0.
- Signature check: from sig=0, vec=8'h08 with f=1 gives 16'h0108; then vec=8'h21 with f=0 gives 16'h0231.
- Errors: send vec=8'h21, f=1, then vec=8'h08, f=0.
  - Required: err_cnt=2, first_fail_vec=8'h21, first_fail_valid=1, pass=0 at done.
- Simultaneous end: end_req and a transfer in the same cycle.
  - Required: the transfer is counted and done is asserted 2 cycles later.
- Reset mid-RUN after 5 transfers with in_valid held high.
  - Required: immediate clear to the reset values, in_ready=0, no transfer counted.
- Saturation with CNT_W=2: 5 mismatching transfers.
  - Required: vec_cnt=3, err_cnt=3, first_fail_vec equals the first vector sent.
